// File: rtl/frame_buffer_ctrl.sv
// Double-buffered 160x120 RGB332 frame buffer: the front bank is scanned out and the back bank is written, with the swap taken at the start of vblank.
// Optional feature macro FB_CLEAR_ON_SWAP_EN: zero the new back bank after every swap.
module frame_buffer_ctrl #(
  parameter int H_VIS       = 640,
  parameter int V_VIS       = 480,
  parameter int SCALE_SHIFT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] hc_in,
  input  logic [9:0] vc_in,
  input  logic       wr_en,
  input  logic [7:0] wr_x,
  input  logic [6:0] wr_y,
  input  logic [7:0] wr_data,
  input  logic       swap_req,
  output logic [7:0] pixel_out,
  output logic       swap_ack,
  output logic       front_bank,
  output logic       clear_busy
);

  localparam int FB_W     = H_VIS >> SCALE_SHIFT;
  localparam int FB_H     = V_VIS >> SCALE_SHIFT;
  localparam int FB_DEPTH = FB_W * FB_H;
  localparam int ADDR_W   = $clog2(FB_DEPTH);
  localparam logic [ADDR_W-1:0] FB_W_A = ADDR_W'(FB_W);

  typedef enum logic [1:0] {IDLE, PENDING, SWAP} swap_state_t;

  swap_state_t       state;
  logic              swap_point;

  logic              visible;
  logic [ADDR_W-1:0] rd_row;
  logic [ADDR_W-1:0] rd_col;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              vis_q1;
  logic              vis_q2;
  logic              bank_q1;
  logic              bank_q2;
  logic [7:0]        rd_data0;
  logic [7:0]        rd_data1;

  logic              wr_in_range;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_bank;
  logic              user_we;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_wa;
  logic [7:0]        ram_wd;
  logic              we0;
  logic              we1;

  logic [7:0] mem0 [FB_DEPTH];
  logic [7:0] mem1 [FB_DEPTH];

  // Read side: blanked positions read address 0 so the RAM index never leaves the bank.
  assign visible = (hc_in < 10'(H_VIS)) && (vc_in < 10'(V_VIS));
  assign rd_row  = ADDR_W'(vc_in >> SCALE_SHIFT);
  assign rd_col  = ADDR_W'(hc_in >> SCALE_SHIFT);
  assign rd_addr = visible ? (rd_row * FB_W_A + rd_col) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr_q <= '0;
      vis_q1    <= 1'b0;
      vis_q2    <= 1'b0;
      bank_q1   <= 1'b0;
      bank_q2   <= 1'b0;
    end else begin
      rd_addr_q <= rd_addr;
      vis_q1    <= visible;
      bank_q1   <= front_bank;
      vis_q2    <= vis_q1;
      bank_q2   <= bank_q1;
    end
  end

  assign pixel_out = vis_q2 ? (bank_q2 ? rd_data1 : rd_data0) : 8'h00;

  // Swap FSM: a request is held until the first vblank line, then taken for one cycle.
  assign swap_point = (hc_in == 10'd0) && (vc_in == 10'(V_VIS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      front_bank <= 1'b0;
      swap_ack   <= 1'b0;
    end else begin
      swap_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (swap_req) begin
            if (swap_point) begin
              state      <= SWAP;
              front_bank <= ~front_bank;
              swap_ack   <= 1'b1;
            end else begin
              state <= PENDING;
            end
          end
        end
        PENDING: begin
          if (swap_point) begin
            state      <= SWAP;
            front_bank <= ~front_bank;
            swap_ack   <= 1'b1;
          end
        end
        SWAP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Write side: the range check stops x overflow from spilling into the next row.
  assign wr_in_range = (wr_x < 8'(FB_W)) && (wr_y < 7'(FB_H));
  assign wr_addr     = ADDR_W'(wr_y) * FB_W_A + ADDR_W'(wr_x);
  // front_bank has already flipped in SWAP, so that cycle still targets the old back bank.
  assign wr_bank     = (state == SWAP) ? front_bank : ~front_bank;
  assign user_we     = wr_en && wr_in_range && !clear_busy;

`ifdef FB_CLEAR_ON_SWAP_EN
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(FB_DEPTH - 1);

  logic              clr_active;
  logic [ADDR_W-1:0] clr_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_active <= 1'b0;
      clr_addr   <= '0;
    end else if (state == SWAP) begin
      clr_active <= 1'b1;
      clr_addr   <= '0;
    end else if (clr_active) begin
      if (clr_addr == LAST_A) begin
        clr_active <= 1'b0;
      end else begin
        clr_addr <= clr_addr + ADDR_W'(1);
      end
    end
  end

  assign clear_busy = clr_active;
  assign ram_we     = user_we || clr_active;
  assign ram_wa     = clr_active ? clr_addr : wr_addr;
  assign ram_wd     = clr_active ? 8'h00 : wr_data;
`else
  assign clear_busy = 1'b0;
  assign ram_we     = user_we;
  assign ram_wa     = wr_addr;
  assign ram_wd     = wr_data;
`endif

  assign we0 = ram_we && !wr_bank;
  assign we1 = ram_we && wr_bank;

  // Banks carry no reset so their contents survive rst.
  always_ff @(posedge clk) begin
    if (we0) begin
      mem0[ram_wa] <= ram_wd;
    end
    rd_data0 <= mem0[rd_addr_q];
  end

  always_ff @(posedge clk) begin
    if (we1) begin
      mem1[ram_wa] <= ram_wd;
    end
    rd_data1 <= mem1[rd_addr_q];
  end

endmodule

// File: doc/frame_buffer_ctrl.md
FRAME_BUFFER_CTRL -- requirements
Module: frame_buffer_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset: the clock is clk, and reset is rst, which is asynchronous and active-high.
REQ-002 The block SHALL have the following ports:
  - clk  in  1  pixel clock (25 MHz), all logic rising-edge
  - rst  in  1  asynchronous active-high reset
  - hc_in  in  10  horizontal counter from VGA timing, 0..799
  - vc_in  in  10  vertical counter from VGA timing, 0..524
  - wr_en  in  1  write strobe from graphics stage
  - wr_x  in  8  write column, 0..159
  - wr_y  in  7  write row, 0..119
  - wr_data  in  8  RGB332 pixel, [7:5] R, [4:2] G, [1:0] B
  - swap_req  in  1  one-cycle pulse: back buffer complete
  - pixel_out  out  8  RGB332 pixel to VGA stage
  - swap_ack  out  1  one-cycle pulse: swap taken
  - front_bank  out  1  bank currently scanned out
  - clear_busy  out  1  back bank clear in progress
REQ-003 The block SHALL have the following parameters (name, default, meaning):
  - H_VIS, 640, visible columns
  - V_VIS, 480, visible rows
  - SCALE_SHIFT, 2, log2 pixel replication; gives a 160x120 buffer

Function
REQ-004 The block SHALL hold two banks of 19200 x 8 bits in synchronous block RAM: the front bank is read and the back bank is written.
REQ-005 The read address SHALL be (vc_in>>2)*160 + (hc_in>>2), 15 bits, computed without overflow for all visible hc_in/vc_in.
REQ-006 Read latency SHALL be exactly 2 clk: cycle 0 registers the address, cycle 1 is the RAM registered read, and pixel_out is valid at cycle 2.
REQ-007 The visible flag (hc_in<640 && vc_in<480) SHALL be pipelined 2 stages alongside the read; pixel_out SHALL be 8'h00 when the delayed flag is 0.
REQ-008 A write SHALL occur when wr_en=1, wr_x<160, wr_y<120 and clear_busy=0, to back-bank address wr_y*160+wr_x.
REQ-009 Out-of-range writes SHALL be dropped silently and SHALL NOT wrap into another row.
REQ-010 The swap FSM SHALL have states IDLE, PENDING and SWAP:
  - IDLE->PENDING on swap_req=1.
  - PENDING->SWAP at the swap point (hc_in==0 && vc_in==480).
  - SWAP->IDLE after 1 cycle.
REQ-011 A swap_req coinciding with the swap point while in IDLE SHALL be taken in that frame (direct IDLE->SWAP).
REQ-012 In SWAP, front_bank SHALL toggle and swap_ack SHALL be 1 for exactly that cycle.
REQ-013 swap_req while PENDING or SWAP SHALL be ignored, with no queueing.
REQ-014 A write in the SWAP cycle SHALL go to the pre-toggle back bank.
REQ-015 front_bank SHALL change only at the swap point, so no bank change occurs during visible scan.

Reset
REQ-016 Reset SHALL force front_bank=0, FSM=IDLE, pixel_out=8'h00, swap_ack=0, clear_busy=0, and clear both pipeline stages.
REQ-017 RAM contents SHALL be retained across reset; a reset mid-frame SHALL abort any pending swap and any clear in progress.
REQ-018 After rst deasserts, pixel_out SHALL be valid 2 clk after the first visible hc_in/vc_in.

Configuration
REQ-019 With FB_CLEAR_ON_SWAP_EN defined, each swap SHALL start a clear of the new back bank:
  - clear_busy=1 from the cycle after SWAP for exactly 19200 cycles.
  - Writes 8'h00 to addresses 0..19199 in ascending order.
  - wr_en is ignored while clearing.
REQ-020 Without FB_CLEAR_ON_SWAP_EN, clear_busy SHALL be tied 0 and the back bank SHALL keep its previous contents after a swap.

Verification
REQ-021 The bench SHALL cover these scenarios (stimulus -> response):
  - Write 8'hE0 at (x=5,y=3) into bank 1, swap, then scan hc=20..23 at vc=12 -> pixel_out=8'hE0 two cycles after each of the 4 hc values.
  - Drive hc=640 or vc=480 with RAM filled 8'hFF -> pixel_out=8'h00 two cycles later.
  - Pulse swap_req at vc=100, then again at vc=200 -> one swap_ack at (hc=0,vc=480), front_bank toggles once.
  - Pulse swap_req exactly at hc=0,vc=480 -> swap_ack and front_bank toggle in that cycle; a write in that cycle lands in the old back bank.
  - Write with wr_x=160, wr_y=0 -> no RAM location changes (check address 0 of row 1 unchanged).
  - With FB_CLEAR_ON_SWAP_EN: swap -> clear_busy high 19200 cycles; new back bank reads all 8'h00; assert rst mid-clear -> clear_busy=0 immediately.
